systolic_feeder: RTL and testbench

- Transmit-side companion to the N x N systolic matrix-multiply array.
- Accepts two full N x N operand matrices through a start/ready handshake, then streams them into the array's west (A) and north (B) edges.
- Applies the diagonal skew, the accumulator-sync pulse and the enable window, then signals completion.
- Sits between the operand buffer/controller and the array instance.

---
 rtl/systolic_feeder_pkg.sv | 13 +
 rtl/systolic_skew_lane.sv | 17 +
 rtl/systolic_feeder.sv | 121 ++++++++++++
 tb/tb_systolic_feeder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/systolic_feeder_pkg.sv
// systolic_feeder_pkg: shared state encoding and skew-window helpers for the systolic feeder
package systolic_feeder_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, FEED, DRAIN, DONE} state_t;
  function automatic int feed_len(input int n);
    return 2 * n - 1;
  endfunction
  function automatic int drain_len(input int n, input int pe_lat);
    return n - 1 + pe_lat;
  endfunction
  function automatic int flat_idx(input int r, input int c, input int n);
    return r * n + c;
  endfunction
endpackage

// File: rtl/systolic_skew_lane.sv
// systolic_skew_lane: picks element t-LANE of a row/column vector, zero outside the lane window
module systolic_skew_lane #(
  parameter int W    = 32,
  parameter int N    = 3,
  parameter int TW   = 4,
  parameter int LANE = 0
) (
  input  logic [W*N-1:0] vec,
  input  logic [TW-1:0]  t,
  output logic [W-1:0]   elem
);
  always_comb begin
    elem = '0;
    for (int k = 0; k < N; k++)
      if (int'(t) == k + LANE) elem = vec[k*W +: W];
  end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: latches A/B operands and streams them skewed into a systolic array
module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int W      = 32,
  parameter int N      = 3,
  parameter int PE_LAT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_stall,
  input  logic [W*N*N-1:0] i_A_mat,
  input  logic [W*N*N-1:0] i_B_mat,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_en,
  output logic             o_sync,
  output logic             o_mode,
  output logic [W*N-1:0]   o_A,
  output logic [W*N-1:0]   o_B,
  output logic             o_done
);
  localparam int FEED_LEN  = feed_len(N);
  localparam int DRAIN_LEN = drain_len(N, PE_LAT);
  localparam int TW        = $clog2(3 * N + PE_LAT);
  state_t state, state_nxt;
  logic [TW-1:0] t, t_nxt;
  logic [W*N*N-1:0] a_q, b_q;
  logic [W*N-1:0] a_lanes, b_lanes, a_d, b_d;
  logic accept, hold, ready_d, busy_d, en_d, sync_d, done_d;
  assign accept = i_start && o_ready;
  // lanes are computed from the next t so the registered outputs line up with the state they belong to
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [W*N-1:0] col;
    for (genvar k = 0; k < N; k++) begin : g_col
      assign col[k*W +: W] = b_q[flat_idx(k, i, N)*W +: W];
    end
    systolic_skew_lane #(.W(W), .N(N), .TW(TW), .LANE(i)) u_a (
      .vec (a_q[flat_idx(i, 0, N)*W +: W*N]),
      .t   (t_nxt),
      .elem(a_lanes[i*W +: W])
    );
    systolic_skew_lane #(.W(W), .N(N), .TW(TW), .LANE(i)) u_b (
      .vec (col),
      .t   (t_nxt),
      .elem(b_lanes[i*W +: W])
    );
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
    end
  end
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    case (state)
      IDLE:  if (accept) begin
        state_nxt = SYNC;
        t_nxt     = '0;
      end
      SYNC:  begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED:  if (!i_stall) begin
        state_nxt = (t == TW'(FEED_LEN - 1)) ? DRAIN : FEED;
        t_nxt     = (t == TW'(FEED_LEN - 1)) ? '0 : t + TW'(1);
      end
      DRAIN: if (!i_stall) begin
        state_nxt = (t == TW'(DRAIN_LEN - 1)) ? DONE : DRAIN;
        t_nxt     = (t == TW'(DRAIN_LEN - 1)) ? '0 : t + TW'(1);
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    hold    = i_stall && (state == FEED || state == DRAIN);
    ready_d = state_nxt == IDLE;
    busy_d  = state_nxt == SYNC || state_nxt == FEED || state_nxt == DRAIN;
    en_d    = (state_nxt == FEED || state_nxt == DRAIN) && !hold;
    sync_d  = state_nxt == SYNC;
    done_d  = state_nxt == DONE;
    a_d     = hold ? o_A : (state_nxt == FEED ? a_lanes : '0);
    b_d     = hold ? o_B : (state_nxt == FEED ? b_lanes : '0);
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
      o_en    <= 1'b0;
      o_sync  <= 1'b0;
      o_done  <= 1'b0;
      o_mode  <= 1'b0;
      o_A     <= '0;
      o_B     <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      o_ready <= ready_d;
      o_busy  <= busy_d;
      o_en    <= en_d;
      o_sync  <= sync_d;
      o_done  <= done_d;
      o_A     <= a_d;
      o_B     <= b_d;
      if (accept) begin
        o_mode <= i_mode;
        a_q    <= i_A_mat;
        b_q    <= i_B_mat;
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: scoreboard bench; driver queues expected per-cycle outputs, monitor compares
module tb_systolic_feeder;
  localparam int W = 8, N = 3, PE_LAT = 1;
  localparam int MW = W * N * N, LW = W * N;
  logic i_clk = 0, i_rst = 1, i_start = 0, i_mode = 0, i_stall = 0;
  logic [MW-1:0] i_A_mat = '0, i_B_mat = '0;
  logic o_ready, o_busy, o_en, o_sync, o_mode, o_done;
  logic [LW-1:0] o_A, o_B;
  typedef struct {
    int cyc;
    logic sync, en, done, mode;
    logic [LW-1:0] a, b;
  } exp_t;
  exp_t q[$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  systolic_feeder #(.W(W), .N(N), .PE_LAT(PE_LAT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_stall(i_stall),
    .i_A_mat(i_A_mat), .i_B_mat(i_B_mat), .o_ready(o_ready), .o_busy(o_busy), .o_en(o_en),
    .o_sync(o_sync), .o_mode(o_mode), .o_A(o_A), .o_B(o_B), .o_done(o_done)
  );
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;
  function automatic logic [LW-1:0] skew_a(input logic [MW-1:0] m, input int t);
    logic [LW-1:0] r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*W +: W] = m[(i*N + t - i)*W +: W];
    return r;
  endfunction
  function automatic logic [LW-1:0] skew_b(input logic [MW-1:0] m, input int t);
    logic [LW-1:0] r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*W +: W] = m[((t - j)*N + j)*W +: W];
    return r;
  endfunction
  task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic push(input int c, input logic s, input logic e, input logic d, input logic md,
                      input logic [LW-1:0] a, input logic [LW-1:0] b);
    exp_t x;
    x.cyc = c; x.sync = s; x.en = e; x.done = d; x.mode = md; x.a = a; x.b = b;
    q.push_back(x);
  endtask
  always @(negedge i_clk) begin
    if (o_busy || o_done) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: cyc=%0d sync=%b en=%b done=%b A=%h B=%h with nothing expected",
                 cyc, o_sync, o_en, o_done, o_A, o_B);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (cyc != e.cyc || o_sync !== e.sync || o_en !== e.en || o_done !== e.done ||
            o_mode !== e.mode || o_A !== e.a || o_B !== e.b || o_ready !== 1'b0 || o_busy !== !e.done) begin
          n_fail++;
          $display("FAIL stream: got cyc=%0d sync=%b en=%b done=%b mode=%b ready=%b busy=%b A=%h B=%h; expected cyc=%0d sync=%b en=%b done=%b mode=%b ready=0 busy=%b A=%h B=%h",
                   cyc, o_sync, o_en, o_done, o_mode, o_ready, o_busy, o_A, o_B,
                   e.cyc, e.sync, e.en, e.done, e.mode, !e.done, e.a, e.b);
        end
      end
    end
  end
  task automatic wait_ready(output int acc);
    acc = -1;
    for (int k = 0; k < 100; k++) begin
      if (o_ready) begin
        acc = cyc;
        return;
      end
      @(negedge i_clk);
    end
    n_chk++;
    n_fail++;
    $display("FAIL ready_timeout: o_ready stayed %b, expected 1", o_ready);
  endtask
  task automatic run_job(input logic [MW-1:0] a, input logic [MW-1:0] b, input logic md,
                         input int stall_at, input int stall_len, input bit keep_start,
                         input bit toggle, input int rst_at);
    int acc, c, done_cyc;
    wait_ready(acc);
    if (acc < 0) return;
    i_A_mat = a; i_B_mat = b; i_mode = md; i_start = 1;
    c = acc + 1;
    push(c++, 1, 0, 0, md, '0, '0);
    for (int t = 0; t < 2*N - 1; t++) begin
      push(c++, 0, 1, 0, md, skew_a(a, t), skew_b(b, t));
      if (t == stall_at)
        for (int s = 0; s < stall_len; s++) push(c++, 0, 0, 0, md, skew_a(a, t), skew_b(b, t));
    end
    for (int d = 0; d < N - 1 + PE_LAT; d++) push(c++, 0, 1, 0, md, '0, '0);
    done_cyc = c;
    push(c, 0, 0, 1, md, '0, '0);
    if (rst_at >= 0)
      while (q.size() > 0 && q[$].cyc > acc + 1 + rst_at) void'(q.pop_back());
    while (cyc < done_cyc) begin
      @(negedge i_clk);
      if (!keep_start) i_start = 0;
      if (toggle) i_mode = ~i_mode;
      if (stall_len > 0 && cyc == acc + 2 + stall_at) i_stall = 1;
      if (cyc == acc + 2 + stall_at + stall_len) i_stall = 0;
      if (rst_at >= 0 && cyc == acc + 1 + rst_at) begin
        i_rst = 1;
        break;
      end
    end
    @(negedge i_clk);
    if (rst_at >= 0) begin
      i_rst = 0;
      check("rst_busy", LW'(o_busy), '0);
      check("rst_en", LW'(o_en), '0);
      check("rst_ready", LW'(o_ready), LW'(1));
      check("rst_lanes_a", o_A, '0);
      check("rst_lanes_b", o_B, '0);
      repeat (12) @(negedge i_clk);
      check("rst_no_done_pending", LW'(q.size()), '0);
    end else begin
      check("ready_after_done", LW'(o_ready), LW'(1));
    end
  endtask
  initial begin
    logic [MW-1:0] a1, id, a2, b2;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        a1[(r*N + c)*W +: W] = W'(r*N + c + 1);
        id[(r*N + c)*W +: W] = (r == c) ? W'(1) : W'(0);
        a2[(r*N + c)*W +: W] = W'(8'hA0 + r*16 + c);
        b2[(r*N + c)*W +: W] = W'(8'h10 + c*16 + r);
      end
    repeat (3) @(negedge i_clk);
    i_rst = 0;
    @(negedge i_clk);
    check("reset_ready", LW'(o_ready), LW'(1));
    check("reset_busy", LW'(o_busy), '0);
    check("reset_en", LW'(o_en), '0);
    check("reset_sync", LW'(o_sync), '0);
    check("reset_done", LW'(o_done), '0);
    check("reset_mode", LW'(o_mode), '0);
    check("reset_A", o_A, '0);
    check("reset_B", o_B, '0);
    repeat (3) @(negedge i_clk);
    check("idle_ready", LW'(o_ready), LW'(1));
    run_job(a1, id, 0, -1, 0, 0, 0, -1);
    run_job(a1, id, 0, 2, 3, 0, 0, -1);
    run_job(a2, b2, 1, 4, 2, 1, 1, -1);
    run_job(b2, a2, 0, -1, 0, 0, 0, -1);
    run_job(a2, id, 1, 0, 1, 0, 1, 7);
    repeat (5) @(negedge i_clk);
    check("queue_drained", LW'(q.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
